// File: rtl/rng_sched_pkg.sv
// Shared types and constants for the random-byte request scheduler.
package rng_sched_pkg;

  localparam int unsigned SEED_W = 4;
  localparam int unsigned BYTE_W = 8;

  localparam logic [SEED_W-1:0] DEFAULT_SEED = 4'b1010;

  typedef enum logic [1:0] {
    LOAD = 2'd0,
    WARM = 2'd1,
    RUN  = 2'd2
  } state_e;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/rng_request_scheduler_rr_arbiter.sv
// Combinational round-robin arbiter: first asserted req at or after ptr wins.
module rr_arbiter #(
  parameter int unsigned N_REQ = 3,
  parameter int unsigned PTR_W = 2
) (
  input  logic [N_REQ-1:0] req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N_REQ-1:0] grant
);

  always_comb begin
    int unsigned idx;
    logic        found;
    grant = '0;
    found = 1'b0;
    idx   = 0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      idx = 32'(ptr) + k;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req[idx[PTR_W-1:0]]) begin
        grant[idx[PTR_W-1:0]] = 1'b1;
        found                 = 1'b1;
      end
    end
  end

endmodule

// File: rtl/rng_request_scheduler.sv
// Seeds the random-byte generator, waits out warm-up, then shares its bytes among requesters.
// Optional RNG_SCHED_PRIORITY_EN gives requester 0 fixed top priority over the round-robin group.
module rng_request_scheduler
  import rng_sched_pkg::*;
#(
  parameter int unsigned N_REQ         = 3,
  parameter int unsigned WARMUP_CYCLES = 16,
  parameter int unsigned MIN_GAP       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              reseed,
  input  logic [SEED_W-1:0] seed_in,
  input  logic [N_REQ-1:0]  req,
  input  logic [BYTE_W-1:0] gen_out,
  output logic [SEED_W-1:0] gen_seed,
  output logic              gen_load,
  output logic [N_REQ-1:0]  grant,
  output logic [BYTE_W-1:0] rand_out,
  output logic              rand_valid,
  output logic              ready
);

  localparam int unsigned PTR_W = $clog2(N_REQ);
  localparam int unsigned CNT_W = $clog2(max_u(WARMUP_CYCLES, MIN_GAP) + 1);

  state_e              state_q, state_d;
  logic [SEED_W-1:0]   seed_q, seed_d;
  logic                gen_load_q, gen_load_d;
  logic [N_REQ-1:0]    grant_q, grant_d;
  logic [BYTE_W-1:0]   rand_q, rand_d;
  logic                valid_q, valid_d;
  logic                ready_q, ready_d;
  logic [CNT_W-1:0]    gap_q, gap_d;
  logic [CNT_W-1:0]    warm_q, warm_d;
  logic [PTR_W-1:0]    ptr_q, ptr_d;

  logic [N_REQ-1:0]    arb_req, arb_grant, win;
  logic [PTR_W-1:0]    win_idx, ptr_nxt;

  rr_arbiter #(.N_REQ(N_REQ), .PTR_W(PTR_W)) u_arb (
    .req   (arb_req),
    .ptr   (ptr_q),
    .grant (arb_grant)
  );

`ifdef RNG_SCHED_PRIORITY_EN
  // Requester 0 pre-empts; the rest rotate among themselves.
  assign arb_req = req & ~N_REQ'(1);
  assign win     = req[0] ? N_REQ'(1) : arb_grant;
`else
  assign arb_req = req;
  assign win     = arb_grant;
`endif

  always_comb begin
    win_idx = '0;
    for (int unsigned k = 0; k < N_REQ; k++) begin
      if (win[k]) win_idx = PTR_W'(k);
    end
    ptr_nxt = (win_idx == PTR_W'(N_REQ - 1)) ? '0 : win_idx + PTR_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= LOAD;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (reseed) begin
      state_d = LOAD;
    end else begin
      case (state_q)
        LOAD:    state_d = WARM;
        WARM:    if (warm_q == CNT_W'(WARMUP_CYCLES - 1)) state_d = RUN;
        RUN:     state_d = RUN;
        default: state_d = LOAD;
      endcase
    end
  end

  // Registered-output next values; reseed overrides everything, including a pending grant.
  always_comb begin
    seed_d     = seed_q;
    gen_load_d = 1'b0;
    grant_d    = '0;
    rand_d     = rand_q;
    valid_d    = 1'b0;
    gap_d      = (gap_q != '0) ? gap_q - CNT_W'(1) : '0;
    warm_d     = '0;
    ptr_d      = ptr_q;
    ready_d    = (state_d == RUN);
    if (reseed) begin
      seed_d = (seed_in == '0) ? DEFAULT_SEED : seed_in;
      gap_d  = '0;
    end else begin
      case (state_q)
        LOAD: begin
          gen_load_d = 1'b1;
          gap_d      = '0;
        end
        WARM: warm_d = warm_q + CNT_W'(1);
        RUN: begin
          if ((req != '0) && (gap_q == '0)) begin
            grant_d = win;
            rand_d  = gen_out;
            valid_d = 1'b1;
            gap_d   = CNT_W'(MIN_GAP - 1);
            ptr_d   = ptr_nxt;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      seed_q     <= DEFAULT_SEED;
      gen_load_q <= 1'b0;
      grant_q    <= '0;
      rand_q     <= '0;
      valid_q    <= 1'b0;
      ready_q    <= 1'b0;
      gap_q      <= '0;
      warm_q     <= '0;
      ptr_q      <= '0;
    end else begin
      seed_q     <= seed_d;
      gen_load_q <= gen_load_d;
      grant_q    <= grant_d;
      rand_q     <= rand_d;
      valid_q    <= valid_d;
      ready_q    <= ready_d;
      gap_q      <= gap_d;
      warm_q     <= warm_d;
      ptr_q      <= ptr_d;
    end
  end

  assign gen_seed   = seed_q;
  assign gen_load   = gen_load_q;
  assign grant      = grant_q;
  assign rand_out   = rand_q;
  assign rand_valid = valid_q;
  assign ready      = ready_q;

endmodule

// File: tb/tb_rng_request_scheduler.sv
// Directed and randomized bench for rng_request_scheduler with a cycle-level reference model.
module tb_rng_request_scheduler;

  localparam int N       = 3;
  localparam int WARMUP  = 16;
  localparam int MIN_GAP = 8;

  logic       clk, rst, reseed;
  logic [3:0] seed_in;
  logic [2:0] req;
  logic [7:0] gen_out;
  logic [3:0] gen_seed;
  logic       gen_load;
  logic [2:0] grant;
  logic [7:0] rand_out;
  logic       rand_valid;
  logic       ready;

  rng_request_scheduler #(.N_REQ(N), .WARMUP_CYCLES(WARMUP), .MIN_GAP(MIN_GAP)) dut (
    .clk        (clk),
    .rst        (rst),
    .reseed     (reseed),
    .seed_in    (seed_in),
    .req        (req),
    .gen_out    (gen_out),
    .gen_seed   (gen_seed),
    .gen_load   (gen_load),
    .grant      (grant),
    .rand_out   (rand_out),
    .rand_valid (rand_valid),
    .ready      (ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  // Reference model: phase 0=loading, 1=warming, 2=running; gap tracked by grant timestamps.
  int         m_phase, m_warm, m_ptr, m_last, m_cyc;
  bit         m_have;
  logic [3:0] m_seed;
  logic [7:0] m_rand;
  logic [2:0] exp_grant;
  logic       exp_valid, exp_load, exp_ready;
  logic [7:0] cap_gen;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(input logic [2:0] r, input int ptr);
`ifdef RNG_SCHED_PRIORITY_EN
    if (r[0]) return 0;
`endif
    for (int k = 0; k < N; k++) begin
      int idx;
      idx = (ptr + k) % N;
`ifdef RNG_SCHED_PRIORITY_EN
      if (idx == 0) continue;
`endif
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  task automatic model_reset();
    m_phase = 0; m_warm = 0; m_ptr = 0; m_last = 0; m_have = 0;
    m_seed = 4'hA; m_rand = 8'h00;
    exp_grant = 3'b000; exp_valid = 1'b0; exp_load = 1'b0; exp_ready = 1'b0;
  endtask

  task automatic model_step(input logic rs, input logic [3:0] s, input logic [2:0] r,
                            input logic [7:0] g);
    int w;
    m_cyc++;
    exp_grant = 3'b000; exp_valid = 1'b0; exp_load = 1'b0;
    if (rs) begin
      m_seed  = (s == 4'h0) ? 4'hA : s;
      m_phase = 0;
      m_have  = 0;
    end else if (m_phase == 0) begin
      exp_load = 1'b1;
      m_phase  = 1;
      m_warm   = WARMUP;
      m_have   = 0;
    end else if (m_phase == 1) begin
      m_warm--;
      if (m_warm == 0) m_phase = 2;
    end else if (r != 3'b000 && (!m_have || (m_cyc - m_last) >= MIN_GAP)) begin
      w         = pick(r, m_ptr);
      exp_grant = 3'(1 << w);
      exp_valid = 1'b1;
      m_rand    = g;
      m_have    = 1;
      m_last    = m_cyc;
      m_ptr     = (w + 1) % N;
    end
    exp_ready = (m_phase == 2);
  endtask

  task automatic compare_all(input string pfx);
    check({pfx, "_grant"},    32'(grant),      32'(exp_grant));
    check({pfx, "_valid"},    32'(rand_valid), 32'(exp_valid));
    check({pfx, "_rand_out"}, 32'(rand_out),   32'(m_rand));
    check({pfx, "_gen_load"}, 32'(gen_load),   32'(exp_load));
    check({pfx, "_gen_seed"}, 32'(gen_seed),   32'(m_seed));
    check({pfx, "_ready"},    32'(ready),      32'(exp_ready));
  endtask

  task automatic tick();
    logic       rs;
    logic [3:0] s;
    logic [2:0] r;
    logic [7:0] g;
    rs = reseed; s = seed_in; r = req; g = gen_out;
    @(posedge clk);
    model_step(rs, s, r, g);
    cap_gen = g;
    #1;
    compare_all("cyc");
    gen_out = 8'($urandom);
  endtask

  task automatic expect_grant(input string tag, input logic [2:0] g, input int gap);
    int n;
    n = 0;
    do begin
      tick();
      n++;
    end while (!rand_valid && n < 100);
    check({tag, "_seen"},  32'(rand_valid), 32'(1));
    check({tag, "_grant"}, 32'(grant),      32'(g));
    check({tag, "_byte"},  32'(rand_out),   32'(cap_gen));
    if (gap > 0) check({tag, "_spacing"}, 32'(n), 32'(gap));
  endtask

  task automatic wait_ready(input string tag, input int exp_n);
    int n;
    n = 0;
    while (!ready && n < 100) begin
      tick();
      n++;
    end
    check(tag, 32'(n), 32'(exp_n));
  endtask

  initial begin
    logic seen;
    m_cyc = 0;
    rst = 1'b1; reseed = 1'b0; seed_in = 4'h0; req = 3'b000; gen_out = 8'h5C;
    model_reset();
    #2;
    compare_all("reset");
    @(negedge clk);
    rst = 1'b0;

    // Load pulse with default seed, then warm-up length
    tick();
    check("a_load", 32'(gen_load), 32'(1));
    check("a_seed", 32'(gen_seed), 32'hA);
    wait_ready("a_warm_len", WARMUP);

    // All three requesting, then requester 0 drops
    req = 3'b111;
`ifdef RNG_SCHED_PRIORITY_EN
    expect_grant("b0", 3'b001, 1);
    expect_grant("b1", 3'b001, MIN_GAP);
    expect_grant("b2", 3'b001, MIN_GAP);
    expect_grant("b3", 3'b001, MIN_GAP);
`else
    expect_grant("b0", 3'b001, 1);
    expect_grant("b1", 3'b010, MIN_GAP);
    expect_grant("b2", 3'b100, MIN_GAP);
    expect_grant("b3", 3'b001, MIN_GAP);
`endif
    req = 3'b110;
    expect_grant("b4", 3'b010, MIN_GAP);
    expect_grant("b5", 3'b100, MIN_GAP);
    expect_grant("b6", 3'b010, MIN_GAP);

    // Request withdrawn during the gap leaves pointer untouched
    req = 3'b000;
    repeat (MIN_GAP) tick();
    req = 3'b001;
    expect_grant("c0", 3'b001, 1);
    seen = 1'b0;
    req = 3'b010;
    repeat (3) begin tick(); seen |= rand_valid; end
    req = 3'b000;
    repeat (MIN_GAP) begin tick(); seen |= rand_valid; end
    check("c_dropped", 32'(seen), 32'(0));
    req = 3'b110;
    expect_grant("c1", 3'b010, 1);

    // Zero seed with simultaneous request
    req = 3'b000;
    repeat (MIN_GAP) tick();
    reseed = 1'b1; seed_in = 4'h0; req = 3'b001;
    tick();
    reseed = 1'b0;
    check("d_grant", 32'(grant), 32'(0));
    check("d_seed",  32'(gen_seed), 32'hA);
    check("d_ready", 32'(ready), 32'(0));
    wait_ready("d_ready_lat", WARMUP + 1);
    expect_grant("d1", 3'b001, 1);
    reseed = 1'b1; seed_in = 4'h5; req = 3'b000;
    tick();
    reseed = 1'b0;
    check("d_seed5", 32'(gen_seed), 32'h5);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 99) < 2) begin
        reseed  = 1'b1;
        seed_in = 4'($urandom);
      end else begin
        reseed = 1'b0;
      end
      if (rand_valid && $urandom_range(0, 1) == 0) req = req & ~grant;
      for (int b = 0; b < N; b++) begin
        if ($urandom_range(0, 9) < 3) req[b] = 1'b1;
        else if ($urandom_range(0, 19) == 0) req[b] = 1'b0;
      end
      tick();
    end
    reseed = 1'b0; req = 3'b000;

    // Asynchronous reset in the middle of warm-up
    reseed = 1'b1; seed_in = 4'h7;
    tick();
    reseed = 1'b0;
    check("f_seed7", 32'(gen_seed), 32'h7);
    repeat (6) tick();
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    compare_all("f_async");
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("f_load", 32'(gen_load), 32'(1));
    wait_ready("f_warm_len", WARMUP);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
